cpu_io_responder: RTL and testbench

//  Synthesizable, parametrised I/O-bus responder for DCP-6 CPU bring-up and self-test.

---
 rtl/cpu_io_pkg.sv | 40 ++++
 rtl/io_fifo.sv | 67 ++++++
 rtl/cpu_io_responder.sv | 157 +++++++++++++++
 tb/tb_cpu_io_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the DCP-6 I/O-bus responder: register offsets,
// STAT bit layout and a constant log2 helper.
package cpu_io_pkg;

   // Register offsets within a channel's two-word window
   localparam int unsigned OFS_DATA = 0;
   localparam int unsigned OFS_STAT = 1;

   // STAT read-back bit positions
   localparam int unsigned STAT_RXNE  = 0;
   localparam int unsigned STAT_RXUF  = 1;
   localparam int unsigned STAT_TXOF  = 2;
   localparam int unsigned STAT_IE    = 3;
   localparam int unsigned STAT_TXCNT = 8;
   localparam int unsigned STAT_RXCNT = 12;

   // STAT write control bits (IE shares bit 3 with its read-back position)
   localparam int unsigned CTL_FLUSH_RX = 0;
   localparam int unsigned CTL_FLUSH_TX = 1;

   // STAT word as seen by the CPU, before zero-extension/truncation to DW
   typedef struct packed {
      logic [3:0] rx_cnt;
      logic [3:0] tx_cnt;
      logic [3:0] rsvd;
      logic       ie;
      logic       txof;
      logic       rxuf;
      logic       rx_nempty;
   } stat_t;

   // Ceiling log2 for constant sizing
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock FIFO with flush; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module io_fifo
   import cpu_io_pkg::*;
#(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [DW-1:0]          data_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [clog2(DEPTH):0]  count_o,
   output logic [DW-1:0]          head_o
);

   localparam int unsigned IW = clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          push_ok, pop_ok;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);

   // A pop frees the slot being written, so a full FIFO still accepts a push
   // in the same cycle; flush overrides both.
   assign pop_ok  = pop_i & ~empty_o & ~flush_i;
   assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

   // Pointer next-state
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         rd_d = wr_q;
      end else begin
         if (push_ok) wr_d = wr_q + PW'(1);
         if (pop_ok)  rd_d = rd_q + PW'(1);
      end
   end

   // Pointer registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q[IW-1:0]] <= data_i;
   end

   assign head_o  = empty_o ? '0 : mem_q[rd_q[IW-1:0]];
   assign count_o = wr_q - rd_q;

endmodule

// File: rtl/cpu_io_responder.sv
// DCP-6 CPU I/O-bus responder: NCH channels, each with an RX FIFO (host to CPU)
// and a TX FIFO (CPU to host), plus sticky RXUF/TXOF flags.
// Build option: define IOR_IRQ_EN to enable the per-channel IE bit and irq output.
module cpu_io_responder
   import cpu_io_pkg::*;
#(
   parameter int unsigned   NCH   = 4,
   parameter int unsigned   DW    = 16,
   parameter int unsigned   AW    = 8,
   parameter logic [AW-1:0] BASE  = 'h40,
   parameter int unsigned   DEPTH = 8
) (
   input  logic              mclk,
   input  logic              mrst_n,
   input  logic [AW-1:0]     ioaddr,
   input  logic [DW-1:0]     dout,
   input  logic              iord,
   input  logic              iowr,
   output logic [DW-1:0]     din,
   output logic              sel,
   input  logic [NCH*DW-1:0] rx_data,
   input  logic [NCH-1:0]    rx_vld,
   output logic [NCH-1:0]    rx_rdy,
   output logic [NCH*DW-1:0] tx_data,
   output logic [NCH-1:0]    tx_vld,
   input  logic [NCH-1:0]    tx_rdy,
   output logic [NCH-1:0]    irq
);

   localparam int unsigned CW = (NCH > 1) ? clog2(NCH) : 1;
   localparam int unsigned PW = clog2(DEPTH) + 1;
   localparam int unsigned XW = AW + 1;

   logic [AW-1:0]  ofs_c;
   logic [CW-1:0]  ch_c;
   logic           is_stat_c, rd_act_c;

   logic [NCH-1:0] hit, rx_push, rx_pop, rx_flush, tx_push, tx_pop, tx_flush;
   logic [NCH-1:0] stat_rd, stat_wr, rxuf_set, txof_set;
   logic [NCH-1:0] rx_full, rx_empty, tx_full, tx_empty;
   logic [PW-1:0]  rx_cnt [NCH];
   logic [PW-1:0]  tx_cnt [NCH];
   logic [DW-1:0]  rx_head [NCH];
   logic [DW-1:0]  tx_head [NCH];
   stat_t          stat [NCH];

   logic [NCH-1:0] rxuf_q, rxuf_d, txof_q, txof_d, ie_q, ie_d, irq_q, irq_d;

   // Counts above 15 read back as 15
   function automatic logic [3:0] sat15(input logic [PW-1:0] n);
      return (32'(n) > 32'd15) ? 4'hF : 4'(n);
   endfunction

   // Address decode; a simultaneous write suppresses read side effects
   always_comb begin
      ofs_c     = ioaddr - BASE;
      ch_c      = CW'(ofs_c >> 1);
      is_stat_c = (ofs_c[0] == 1'(OFS_STAT));
      sel       = (ioaddr >= BASE) && ({1'b0, ioaddr} < ({1'b0, BASE} + XW'(2 * NCH)));
      rd_act_c  = iord & ~iowr;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign hit[g]      = sel && (ch_c == CW'(g));
      assign stat_rd[g]  = hit[g] & is_stat_c & rd_act_c;
      assign stat_wr[g]  = hit[g] & is_stat_c & iowr;
      assign rx_flush[g] = stat_wr[g] & dout[CTL_FLUSH_RX];
      assign tx_flush[g] = stat_wr[g] & dout[CTL_FLUSH_TX];

      // CPU side of RX: pop on a DATA read, underflow when nothing is queued
      assign rx_pop[g]   = hit[g] & ~is_stat_c & rd_act_c & ~rx_empty[g];
      assign rxuf_set[g] = hit[g] & ~is_stat_c & rd_act_c & rx_empty[g];

      // Host side of RX: a same-cycle CPU pop makes room even when full
      assign rx_rdy[g]   = (~rx_full[g] | rx_pop[g]) & ~rx_flush[g];
      assign rx_push[g]  = rx_vld[g] & rx_rdy[g];

      // TX: CPU DATA write pushes, host pops; a full write without a pop is lost
      assign tx_vld[g]   = ~tx_empty[g];
      assign tx_pop[g]   = tx_vld[g] & tx_rdy[g];
      assign tx_push[g]  = hit[g] & ~is_stat_c & iowr;
      assign txof_set[g] = tx_push[g] & tx_full[g] & ~tx_pop[g];

      assign stat[g] = {sat15(rx_cnt[g]), sat15(tx_cnt[g]), 4'b0000,
                        ie_q[g], txof_q[g], rxuf_q[g], ~rx_empty[g]};

      io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
         .clk_i   (mclk),
         .rst_ni  (mrst_n),
         .push_i  (rx_push[g]),
         .pop_i   (rx_pop[g]),
         .flush_i (rx_flush[g]),
         .data_i  (rx_data[g*DW +: DW]),
         .full_o  (rx_full[g]),
         .empty_o (rx_empty[g]),
         .count_o (rx_cnt[g]),
         .head_o  (rx_head[g])
      );

      io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
         .clk_i   (mclk),
         .rst_ni  (mrst_n),
         .push_i  (tx_push[g]),
         .pop_i   (tx_pop[g]),
         .flush_i (tx_flush[g]),
         .data_i  (dout),
         .full_o  (tx_full[g]),
         .empty_o (tx_empty[g]),
         .count_o (tx_cnt[g]),
         .head_o  (tx_head[g])
      );

      assign tx_data[g*DW +: DW] = tx_head[g];
   end

   // CPU read data: RX head or STAT of the addressed channel, else 0
   always_comb begin
      din = '0;
      for (int c = 0; c < NCH; c++) begin
         if (hit[c]) din = is_stat_c ? DW'(stat[c]) : rx_head[c];
      end
   end

   // Sticky flags (a set beats a clear), IE and registered interrupt
   always_comb begin
      rxuf_d = (rxuf_q & ~stat_rd) | rxuf_set;
      txof_d = (txof_q & ~stat_rd) | txof_set;
`ifdef IOR_IRQ_EN
      ie_d = ie_q;
      for (int c = 0; c < NCH; c++) begin
         if (stat_wr[c]) ie_d[c] = dout[STAT_IE];
      end
      irq_d = ie_q & (~rx_empty | rxuf_q | txof_q);
`else
      ie_d  = '0;
      irq_d = '0;
`endif
   end

   // Flag registers
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         rxuf_q <= '0;
         txof_q <= '0;
         ie_q   <= '0;
         irq_q  <= '0;
      end else begin
         rxuf_q <= rxuf_d;
         txof_q <= txof_d;
         ie_q   <= ie_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_cpu_io_responder.sv
// Scoreboard bench for cpu_io_responder: the driver computes expected outputs
// from a queue-based channel model and pushes them; a monitor pops and compares.
module tb_cpu_io_responder;

   localparam int NCH   = 4;
   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int BASE  = 'h40;
   localparam int DEPTH = 8;

   logic              mclk, mrst_n;
   logic [AW-1:0]     ioaddr;
   logic [DW-1:0]     dout, din;
   logic              iord, iowr, sel;
   logic [NCH*DW-1:0] rx_data, tx_data;
   logic [NCH-1:0]    rx_vld, rx_rdy, tx_vld, tx_rdy, irq;

   cpu_io_responder #(.NCH(NCH), .DW(DW), .AW(AW), .BASE(8'(BASE)), .DEPTH(DEPTH)) dut (
      .mclk(mclk), .mrst_n(mrst_n), .ioaddr(ioaddr), .dout(dout), .iord(iord), .iowr(iowr),
      .din(din), .sel(sel), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
      .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .irq(irq)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct {
      logic [DW-1:0]     din;
      logic              sel;
      logic [NCH-1:0]    rx_rdy;
      logic [NCH-1:0]    tx_vld;
      logic [NCH*DW-1:0] tx_data;
      logic [NCH-1:0]    irq;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 0;
   bit   in_rst = 1;

   // Behavioural channel model
   logic [DW-1:0]  rxq [NCH][$];
   logic [DW-1:0]  txq [NCH][$];
   logic [NCH-1:0] m_rxuf, m_txof, m_ie, m_irq;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   function automatic void clear_model();
      for (int c = 0; c < NCH; c++) begin
         rxq[c].delete();
         txq[c].delete();
      end
      m_rxuf = '0; m_txof = '0; m_ie = '0; m_irq = '0;
   endfunction

   function automatic logic [DW-1:0] stat_word(input int c);
      int rc, tc;
      rc = (rxq[c].size() > 15) ? 15 : rxq[c].size();
      tc = (txq[c].size() > 15) ? 15 : txq[c].size();
      return {4'(rc), 4'(tc), 4'b0000, m_ie[c], m_txof[c], m_rxuf[c], rxq[c].size() != 0};
   endfunction

   // One bus cycle: drive, record expectations from the pre-edge model, then advance the model
   task automatic cyc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rd,
                      input logic wr, input logic [NCH-1:0] rv,
                      input logic [NCH*DW-1:0] rdat, input logic [NCH-1:0] trdy);
      exp_t           e;
      int             ai, ch;
      bit             insel, st, here, frx, ftx, drd, srd, dwr, popok, hpop, txfull;
      logic [NCH-1:0] irq_nx;
      @(posedge mclk);
      #1;
      mrst_n = !in_rst;
      ioaddr = a; dout = d; iord = rd; iowr = wr;
      rx_vld = rv; rx_data = rdat; tx_rdy = trdy;
      if (in_rst) clear_model();
      ai    = int'(a);
      insel = (ai >= BASE) && (ai < BASE + 2 * NCH);
      ch    = (ai - BASE) / 2;
      st    = ((ai - BASE) % 2) != 0;
      e.sel = insel;
      e.irq = m_irq;
      e.din = '0;
      if (insel) e.din = st ? stat_word(ch) : ((rxq[ch].size() != 0) ? rxq[ch][0] : '0);
      e.rx_rdy = '0; e.tx_vld = '0; e.tx_data = '0;
      irq_nx = '0;
      for (int c = 0; c < NCH; c++) begin
         here   = insel && (ch == c);
         frx    = here && st && wr && d[0];
         ftx    = here && st && wr && d[1];
         drd    = here && !st && rd && !wr;
         srd    = here && st && rd && !wr;
         dwr    = here && !st && wr;
         popok  = drd && (rxq[c].size() != 0);
         hpop   = trdy[c] && (txq[c].size() != 0);
         txfull = txq[c].size() >= DEPTH;
         e.rx_rdy[c] = !frx && ((rxq[c].size() < DEPTH) || popok);
         e.tx_vld[c] = txq[c].size() != 0;
         e.tx_data[c*DW +: DW] = e.tx_vld[c] ? txq[c][0] : '0;
`ifdef IOR_IRQ_EN
         irq_nx[c] = m_ie[c] && ((rxq[c].size() != 0) || m_rxuf[c] || m_txof[c]);
`endif
         if (!in_rst) begin
            if (srd) begin m_rxuf[c] = 1'b0; m_txof[c] = 1'b0; end
            if (drd && !popok) m_rxuf[c] = 1'b1;
            if (popok) void'(rxq[c].pop_front());
            if (rv[c] && e.rx_rdy[c]) rxq[c].push_back(rdat[c*DW +: DW]);
            if (frx) rxq[c].delete();
            if (hpop) void'(txq[c].pop_front());
            if (dwr) begin
               if (!txfull || hpop) txq[c].push_back(d);
               else m_txof[c] = 1'b1;
            end
            if (ftx) txq[c].delete();
`ifdef IOR_IRQ_EN
            if (here && st && wr) m_ie[c] = d[3];
`endif
         end
      end
      m_irq = in_rst ? '0 : irq_nx;
      sb.push_back(e);
      mon_en = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic rd_at(input logic [AW-1:0] a);
      cyc(a, '0, 1'b1, 1'b0, '0, '0, '0);
   endtask

   task automatic wr_at(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cyc(a, d, 1'b0, 1'b1, '0, '0, '0);
   endtask

   task automatic push_ch(input int c, input logic [DW-1:0] d);
      logic [NCH*DW-1:0] dat;
      dat = '0;
      dat[c*DW +: DW] = d;
      cyc('0, '0, 1'b0, 1'b0, NCH'(1 << c), dat, '0);
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge mclk);
         if (mon_en) begin
            if (sb.size() == 0) begin
               check("sb_underrun", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("din",     64'(din),     64'(e.din));
               check("sel",     64'(sel),     64'(e.sel));
               check("rx_rdy",  64'(rx_rdy),  64'(e.rx_rdy));
               check("tx_vld",  64'(tx_vld),  64'(e.tx_vld));
               check("tx_data", 64'(tx_data), 64'(e.tx_data));
               check("irq",     64'(irq),     64'(e.irq));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          rd, wr;
      mrst_n = 1'b0; ioaddr = '0; dout = '0; iord = 1'b0; iowr = 1'b0;
      rx_vld = '0; rx_data = '0; tx_rdy = '0;
      clear_model();

      // Reset, then STAT of every channel
      in_rst = 1'b1;
      idle(32);
      in_rst = 1'b0;
      for (int c = 0; c < NCH; c++) rd_at(8'(BASE + 2 * c + 1));

      // ch1: two pushes, three DATA reads (third underflows), two STAT reads
      push_ch(1, 16'h1234);
      push_ch(1, 16'hABCD);
      rd_at(8'h42); rd_at(8'h42); rd_at(8'h42);
      rd_at(8'h43); rd_at(8'h43);

      // ch2: nine writes with no host pop, STAT, then drain
      for (int i = 0; i < 9; i++) wr_at(8'h44, 16'(16'h1000 + i));
      rd_at(8'h45);
      for (int i = 0; i < 10; i++) cyc('0, '0, 1'b0, 1'b0, '0, '0, 4'b0100);

      // ch0: fill RX, then push and read on the same edge
      for (int i = 0; i < DEPTH; i++) push_ch(0, 16'(16'h0A00 + i));
      cyc(8'h40, '0, 1'b1, 1'b0, 4'b0001, 64'h5555, '0);
      rd_at(8'h41);

      // ch3: load both FIFOs, flush both while the host pushes
      push_ch(3, 16'hBEE0); push_ch(3, 16'hBEE1);
      wr_at(8'h46, 16'h0101); wr_at(8'h46, 16'h0102);
      cyc(8'h47, 16'h0003, 1'b0, 1'b1, 4'b1000, {16'hDEAD, 48'h0}, '0);
      rd_at(8'h47);

      // ch0 interrupt: flush, enable IE, push one word, read it back
      wr_at(8'h41, 16'h0001);
      rd_at(8'h41);
      wr_at(8'h41, 16'h0008);
      idle(2);
      push_ch(0, 16'h7777);
      idle(2);
      rd_at(8'h40);
      idle(2);
      wr_at(8'h41, 16'h0000);

      // Out-of-range accesses, including both strobes at once
      cyc(8'h48, 16'hFFFF, 1'b1, 1'b1, '0, '0, '0);
      rd_at(8'h3F);

      // Randomised traffic with one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            in_rst = 1'b1;
            idle(3);
            in_rst = 1'b0;
         end
         a  = AW'(BASE - 2 + int'($urandom_range(0, 2 * NCH + 3)));
         rd = ($urandom_range(0, 2) == 0);
         wr = ($urandom_range(0, 3) == 0);
         d  = DW'($urandom);
         if (wr && a[0] && ($urandom_range(0, 7) != 0)) d[1:0] = 2'b00;
         cyc(a, d, rd, wr, NCH'($urandom & $urandom), {$urandom, $urandom},
             NCH'($urandom & $urandom & $urandom));
      end

      @(negedge mclk);
      #1;
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
